perceptron_train_ctrl: RTL and testbench

//  Training sequencer for the single-layer perceptron datapath. Holds a small bank of training

---
 rtl/perceptron_pkg.sv | 36 +++
 rtl/train_sample_bank.sv | 35 +++
 rtl/perceptron_train_ctrl.sv | 157 +++++++++++++++
 tb/tb_perceptron_train_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/perceptron_pkg.sv
// rtl/perceptron_pkg.sv - shared encodings for the perceptron training controller
//   DELTA_*  : perceptron error codes on the delta bus
//   X*_BIT   : field positions inside a stored {x1,x2,s} sample
//   train_state_t : controller FSM states
`timescale 1ns/1ps
package perceptron_pkg;

  localparam logic [1:0] DELTA_ZERO = 2'b00;
  localparam logic [1:0] DELTA_POS  = 2'b01;
  localparam logic [1:0] DELTA_NEG  = 2'b11;

  localparam int X1_BIT   = 2;
  localparam int X2_BIT   = 1;
  localparam int S_BIT    = 0;
  localparam int SAMPLE_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } train_state_t;

  // The unused encoding 2'b10 still counts as a misclassification so a
  // broken datapath can never make a run look converged.
  function automatic logic is_error(input logic [1:0] d);
    logic e;
    case (d)
      DELTA_ZERO:          e = 1'b0;
      DELTA_POS, DELTA_NEG: e = 1'b1;
      default:             e = 1'b1;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/train_sample_bank.sv
// rtl/train_sample_bank.sv - NSAMP x 3 training sample register file
//   clk, rst_n        : clock, asynchronous active-low reset (clears all entries)
//   wr_en/addr/data   : synchronous write port
//   rd_addr / rd_data : combinational read port
`timescale 1ns/1ps
module train_sample_bank
  import perceptron_pkg::*;
#(
  parameter  int NSAMP = 4,
  localparam int AW    = $clog2(NSAMP)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [SAMPLE_W-1:0] wr_data,
  input  logic [AW-1:0]       rd_addr,
  output logic [SAMPLE_W-1:0] rd_data
);

  logic [SAMPLE_W-1:0] mem [NSAMP];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSAMP; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/perceptron_train_ctrl.sv
// rtl/perceptron_train_ctrl.sv - training sequencer for a single-layer perceptron
//   clk, rst_n           : clock, asynchronous active-low reset
//   ld_en/ld_addr/ld_data: sample bank write ({x1,x2,s}), dropped while busy
//   start                : begin a run, honoured only in IDLE or DONE
//   delta                : perceptron error for the sample presented this cycle
//   x1, x2, s            : sample presented to the perceptron (0 outside RUN)
//   upd_en               : weight update enable (RUN only)
//   busy, done           : run in progress / run finished
//   converged            : last epoch had zero errors (valid with done)
//   epoch, err_cnt       : current or final epoch index and its error count
`timescale 1ns/1ps
module perceptron_train_ctrl
  import perceptron_pkg::*;
#(
  parameter  int NSAMP     = 4,
  parameter  int MAX_EPOCH = 15,
  parameter  int EPW       = 4,
  localparam int AW        = $clog2(NSAMP),
  localparam int CW        = $clog2(NSAMP + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ld_en,
  input  logic [AW-1:0]       ld_addr,
  input  logic [SAMPLE_W-1:0] ld_data,
  input  logic                start,
  input  logic [1:0]          delta,
  output logic                x1,
  output logic                x2,
  output logic                s,
  output logic                upd_en,
  output logic                busy,
  output logic                done,
  output logic                converged,
  output logic [EPW-1:0]      epoch,
  output logic [CW-1:0]       err_cnt
);

  localparam logic [AW-1:0]  LAST_IDX   = AW'(NSAMP - 1);
  localparam logic [EPW-1:0] LAST_EPOCH = EPW'(MAX_EPOCH - 1);

  train_state_t        state_q, state_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic [EPW-1:0]      epoch_q, epoch_d;
  logic [CW-1:0]       err_q, err_d;
  logic                conv_q, conv_d;
  logic [SAMPLE_W-1:0] sample;
  logic                bank_we;

  // Writing only while not busy keeps the bank stable for the whole run;
  // a write coinciding with start lands before the first sample is read.
  assign bank_we = ld_en & ~busy;

  train_sample_bank #(
    .NSAMP (NSAMP)
  ) u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (bank_we),
    .wr_addr (ld_addr),
    .wr_data (ld_data),
    .rd_addr (idx_q),
    .rd_data (sample)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      epoch_q <= '0;
      err_q   <= '0;
      conv_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      epoch_q <= epoch_d;
      err_q   <= err_d;
      conv_q  <= conv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    epoch_d = epoch_q;
    err_d   = err_q;
    conv_d  = conv_q;
    x1      = 1'b0;
    x2      = 1'b0;
    s       = 1'b0;
    upd_en  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          idx_d   = '0;
          epoch_d = '0;
          err_d   = '0;
          conv_d  = 1'b0;
        end
      end

      RUN: begin
        busy   = 1'b1;
        upd_en = 1'b1;
        x1     = sample[X1_BIT];
        x2     = sample[X2_BIT];
        s      = sample[S_BIT];
        if (is_error(delta)) begin
          err_d = err_q + CW'(1);
        end
        // idx parks on the last sample; only CHECK rewinds it to 0.
        if (idx_q == LAST_IDX) begin
          state_d = CHECK;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end

      CHECK: begin
        busy = 1'b1;
        if ((err_q == '0) || (epoch_q == LAST_EPOCH)) begin
          state_d = DONE;
          conv_d  = (err_q == '0);
        end else begin
          state_d = RUN;
          epoch_d = epoch_q + EPW'(1);
          idx_d   = '0;
          err_d   = '0;
        end
      end

      DONE: begin
        done = 1'b1;
        if (start) begin
          state_d = RUN;
          idx_d   = '0;
          epoch_d = '0;
          err_d   = '0;
          conv_d  = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign epoch     = epoch_q;
  assign err_cnt   = err_q;
  assign converged = conv_q;

endmodule

// File: tb/tb_perceptron_train_ctrl.sv
// tb/tb_perceptron_train_ctrl.sv - self-checking bench for perceptron_train_ctrl
`timescale 1ns/1ps
module tb_perceptron_train_ctrl;
  import perceptron_pkg::*;

  localparam int NS = 4;
  localparam int ME = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ld_en;
  logic [1:0] ld_addr;
  logic [2:0] ld_data;
  logic       start;
  logic [1:0] tb_delta;
  logic [1:0] delta;
  logic       x1, x2, s, upd_en, busy, done, converged;
  logic [3:0] epoch;
  logic [2:0] err_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  perceptron_train_ctrl #(
    .NSAMP     (NS),
    .MAX_EPOCH (ME),
    .EPW       (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .start     (start),
    .delta     (delta),
    .x1        (x1),
    .x2        (x2),
    .s         (s),
    .upd_en    (upd_en),
    .busy      (busy),
    .done      (done),
    .converged (converged),
    .epoch     (epoch),
    .err_cnt   (err_cnt)
  );

  // Behavioural perceptron: z = (w1*x1 + w2*x2 + w3 > 0), delta = s - z.
  logic       use_pc;
  logic       pc_init;
  int         pw1, pw2, pw3;
  logic       pz;
  logic [1:0] pc_delta;

  always_comb begin
    pz = ((pw1 * int'(x1)) + (pw2 * int'(x2)) + pw3) > 0;
    if (s == pz)  pc_delta = DELTA_ZERO;
    else if (s)   pc_delta = DELTA_POS;
    else          pc_delta = DELTA_NEG;
  end

  always_ff @(posedge clk) begin
    if (pc_init) begin
      pw1 <= 1;
      pw2 <= 2;
      pw3 <= 0;
    end else if (use_pc && upd_en) begin
      int dv;
      dv = (pc_delta == DELTA_POS) ? 1 : ((pc_delta == DELTA_NEG) ? -1 : 0);
      pw1 <= pw1 + dv * int'(x1);
      pw2 <= pw2 + dv * int'(x2);
      pw3 <= pw3 + dv;
    end
  end

  assign delta = use_pc ? pc_delta : tb_delta;

  function automatic logic [13:0] mk(input logic [2:0] xs, input logic u, input logic b,
                                     input logic d, input logic c, input logic [3:0] ep,
                                     input logic [2:0] er);
    return {xs, u, b, d, c, ep, er};
  endfunction

  function automatic logic [13:0] obs();
    return {x1, x2, s, upd_en, busy, done, converged, epoch, err_cnt};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] a, input logic [2:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    tick();
    ld_en   = 1'b0;
  endtask

  // Reference model state: bank contents and per-epoch/per-sample delta codes.
  logic [2:0] m_bank [NS];
  logic [1:0] dtab   [ME][NS];
  logic [2:0] or_tab [NS];

  task automatic load_bank();
    for (int i = 0; i < NS; i++) load(2'(i), m_bank[i]);
  endtask

  // A run lasts (E+1) epochs of NS+1 cycles; E is the first epoch with no
  // errors, or the last allowed epoch.  Every cycle is compared.
  task automatic run_model(input string nm, input logic hold_start);
    int e_end;
    int sum_end;
    e_end   = ME - 1;
    sum_end = 0;
    for (int e = 0; e < ME; e++) begin
      int n;
      n = 0;
      for (int p = 0; p < NS; p++) if (dtab[e][p] != 2'b00) n++;
      if (n == 0 || e == ME - 1) begin
        e_end   = e;
        sum_end = n;
        break;
      end
    end
    start    = 1'b1;
    tb_delta = 2'b00;
    tick();
    start = hold_start;
    for (int k = 0; k < (e_end + 1) * (NS + 1); k++) begin
      int e, p, n;
      logic [13:0] ex;
      e = k / (NS + 1);
      p = k % (NS + 1);
      n = 0;
      for (int q = 0; q < p; q++) if (dtab[e][q] != 2'b00) n++;
      if (p < NS) ex = mk(m_bank[p], 1'b1, 1'b1, 1'b0, 1'b0, 4'(e), 3'(n));
      else        ex = mk(3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 4'(e), 3'(n));
      chk($sformatf("%s_cyc%0d", nm, k), int'(obs()), int'(ex));
      tb_delta = (p < NS) ? dtab[e][p] : 2'($urandom_range(0, 3));
      tick();
    end
    chk($sformatf("%s_final", nm), int'(obs()),
        int'(mk(3'b000, 1'b0, 1'b0, 1'b1, (sum_end == 0), 4'(e_end), 3'(sum_end))));
    start    = 1'b0;
    tb_delta = 2'b00;
  endtask

  typedef struct {
    logic        st;
    logic        le;
    logic [1:0]  la;
    logic [2:0]  ld;
    logic [1:0]  dl;
    logic [13:0] ex;
  } vec_t;

  vec_t vt [21];

  initial begin
    rst_n = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    start = 1'b0; tb_delta = '0; use_pc = 1'b0; pc_init = 1'b1;
    or_tab[0] = 3'b000; or_tab[1] = 3'b011; or_tab[2] = 3'b101; or_tab[3] = 3'b111;

    // Inputs applied for one cycle; expected outputs seen after that edge.
    vt[0]  = '{1'b0, 1'b1, 2'd0, 3'b000, 2'b00, mk(3'b000, 0, 0, 0, 0, 0, 0)};
    vt[1]  = '{1'b0, 1'b1, 2'd1, 3'b011, 2'b00, mk(3'b000, 0, 0, 0, 0, 0, 0)};
    vt[2]  = '{1'b0, 1'b1, 2'd2, 3'b101, 2'b00, mk(3'b000, 0, 0, 0, 0, 0, 0)};
    vt[3]  = '{1'b1, 1'b1, 2'd3, 3'b111, 2'b00, mk(3'b000, 1, 1, 0, 0, 0, 0)};
    vt[4]  = '{1'b0, 1'b0, 2'd0, 3'b000, 2'b00, mk(3'b011, 1, 1, 0, 0, 0, 0)};
    vt[5]  = '{1'b0, 1'b1, 2'd0, 3'b111, 2'b00, mk(3'b101, 1, 1, 0, 0, 0, 0)};
    vt[6]  = '{1'b0, 1'b0, 2'd0, 3'b000, 2'b00, mk(3'b111, 1, 1, 0, 0, 0, 0)};
    vt[7]  = '{1'b0, 1'b0, 2'd0, 3'b000, 2'b00, mk(3'b000, 0, 1, 0, 0, 0, 0)};
    vt[8]  = '{1'b0, 1'b0, 2'd0, 3'b000, 2'b00, mk(3'b000, 0, 0, 1, 1, 0, 0)};
    vt[9]  = '{1'b1, 1'b0, 2'd0, 3'b000, 2'b00, mk(3'b000, 1, 1, 0, 0, 0, 0)};
    vt[10] = '{1'b0, 1'b0, 2'd0, 3'b000, 2'b01, mk(3'b011, 1, 1, 0, 0, 0, 1)};
    vt[11] = '{1'b1, 1'b0, 2'd0, 3'b000, 2'b11, mk(3'b101, 1, 1, 0, 0, 0, 2)};
    vt[12] = '{1'b0, 1'b0, 2'd0, 3'b000, 2'b00, mk(3'b111, 1, 1, 0, 0, 0, 2)};
    vt[13] = '{1'b0, 1'b0, 2'd0, 3'b000, 2'b10, mk(3'b000, 0, 1, 0, 0, 0, 3)};
    vt[14] = '{1'b0, 1'b0, 2'd0, 3'b000, 2'b01, mk(3'b000, 1, 1, 0, 0, 1, 0)};
    vt[15] = '{1'b0, 1'b0, 2'd0, 3'b000, 2'b00, mk(3'b011, 1, 1, 0, 0, 1, 0)};
    vt[16] = '{1'b0, 1'b0, 2'd0, 3'b000, 2'b00, mk(3'b101, 1, 1, 0, 0, 1, 0)};
    vt[17] = '{1'b0, 1'b0, 2'd0, 3'b000, 2'b00, mk(3'b111, 1, 1, 0, 0, 1, 0)};
    vt[18] = '{1'b0, 1'b0, 2'd0, 3'b000, 2'b00, mk(3'b000, 0, 1, 0, 0, 1, 0)};
    vt[19] = '{1'b0, 1'b0, 2'd0, 3'b000, 2'b00, mk(3'b000, 0, 0, 1, 1, 1, 0)};
    vt[20] = '{1'b0, 1'b1, 2'd1, 3'b000, 2'b00, mk(3'b000, 0, 0, 1, 1, 1, 0)};

    tick();
    tick();
    chk("reset_state", int'(obs()), 0);
    rst_n   = 1'b1;
    pc_init = 1'b0;
    tick();
    chk("idle_after_reset", int'(obs()), 0);

    // Table-driven sequence: loads, LD+START, mid-run write drop, illegal delta.
    for (int i = 0; i < 21; i++) begin
      start = vt[i].st; ld_en = vt[i].le; ld_addr = vt[i].la;
      ld_data = vt[i].ld; tb_delta = vt[i].dl;
      tick();
      chk($sformatf("vec%0d", i), int'(obs()), int'(vt[i].ex));
    end
    start = 1'b0; ld_en = 1'b0; tb_delta = 2'b00;

    // Zero-error run converges in epoch 0.
    for (int i = 0; i < NS; i++) m_bank[i] = or_tab[i];
    load_bank();
    for (int e = 0; e < ME; e++) for (int p = 0; p < NS; p++) dtab[e][p] = DELTA_ZERO;
    run_model("t1", 1'b0);

    // Every sample wrong: runs to the epoch limit unconverged.
    for (int e = 0; e < ME; e++) for (int p = 0; p < NS; p++) dtab[e][p] = DELTA_POS;
    run_model("t2", 1'b1);

    // Random banks and error patterns whose error rate falls with epoch.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NS; i++) m_bank[i] = 3'($urandom_range(0, 7));
      load_bank();
      for (int e = 0; e < ME; e++) begin
        for (int p = 0; p < NS; p++) begin
          if (int'($urandom_range(0, 99)) < 70 - 14 * e)
            dtab[e][p] = ($urandom_range(0, 1) != 0) ? DELTA_POS : DELTA_NEG;
          else
            dtab[e][p] = DELTA_ZERO;
        end
      end
      run_model($sformatf("rnd%0d", r), r[0]);
    end

    // Asynchronous reset in the middle of epoch 2.
    for (int i = 0; i < NS; i++) m_bank[i] = or_tab[i];
    load_bank();
    start = 1'b1;
    tick();
    start    = 1'b0;
    tb_delta = DELTA_POS;
    for (int k = 0; k < 12; k++) tick();
    chk("t4_pre_epoch", int'(epoch), 2);
    chk("t4_pre_busy", int'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t4_async_clear", int'(obs()), 0);
    tick();
    rst_n    = 1'b1;
    tb_delta = 2'b00;
    for (int i = 0; i < NS; i++) m_bank[i] = 3'b000;
    for (int e = 0; e < ME; e++) for (int p = 0; p < NS; p++) dtab[e][p] = DELTA_ZERO;
    run_model("t4_cleared_bank", 1'b0);
    for (int i = 0; i < NS; i++) m_bank[i] = or_tab[i];
    load_bank();
    dtab[0][1] = DELTA_NEG;
    run_model("t4_reload", 1'b0);

    // Closed loop with the behavioural perceptron on the OR table.
    pc_init = 1'b1;
    tick();
    pc_init = 1'b0;
    use_pc  = 1'b1;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 200 && !done; n++) tick();
    chk("t6_done", int'(done), 1);
    chk("t6_converged", int'(converged), 1);
    chk("t6_epoch_below_limit", int'(epoch < 4'd14), 1);
    use_pc = 1'b0;
    for (int i = 0; i < NS; i++) begin
      logic [2:0] smp;
      int z;
      smp = or_tab[i];
      z = ((pw1 * int'(smp[X1_BIT]) + pw2 * int'(smp[X2_BIT]) + pw3) > 0) ? 1 : 0;
      chk($sformatf("t6_z%0d", i), z, int'(smp[S_BIT]));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
